instruction_issuer: RTL and testbench

INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

---
 rtl/instruction_issuer.sv | 137 +++++++++++++
 tb/tb_instruction_issuer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issuer.sv
// instruction_issuer: fetches program words from a ROM and hands them one at a time to a datapath.
module instruction_issuer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int OPCODE_WIDTH      = 4,
    parameter int RESULT_WIDTH      = 12,
    parameter int PROG_ADDR_WIDTH   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         stop,
    output logic [PROG_ADDR_WIDTH-1:0]   prog_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] prog_data,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         start,
    input  logic                         finished,
    input  logic [RESULT_WIDTH-1:0]      result,
    output logic [RESULT_WIDTH-1:0]      last_result,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         illegal,
    output logic                         overflow,
    output logic [15:0]                  instr_count
);
    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, HALT
    } state_t;

    state_t                         state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0]   instruction_q, instruction_d;
    logic [RESULT_WIDTH-1:0]        last_result_q, last_result_d;
    logic                           result_valid_q, result_valid_d;
    logic                           illegal_q, illegal_d;
    logic                           overflow_q, overflow_d;
    logic                           stop_pending_q, stop_pending_d;
    logic [15:0]                    instr_count_q, instr_count_d;
    logic [OPCODE_WIDTH-1:0]        opcode;

    assign opcode       = instruction_q[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign prog_addr    = pc_q;
    assign instruction  = instruction_q;
    assign start        = state_q == ISSUE;
    assign last_result  = last_result_q;
    assign result_valid = result_valid_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == HALT;
    assign illegal      = illegal_q;
    assign overflow     = overflow_q;
    assign instr_count  = instr_count_q;

    // Next-state and datapath-register updates; a stop request is latched and only honoured at NEXT.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instruction_d  = instruction_q;
        last_result_d  = last_result_q;
        result_valid_d = 1'b0;
        illegal_d      = illegal_q;
        overflow_d     = overflow_q;
        stop_pending_d = stop_pending_q | (stop && state_q != IDLE && state_q != HALT);
        instr_count_d  = instr_count_q;
        case (state_q)
            IDLE: if (run) begin
                pc_d           = '0;
                illegal_d      = 1'b0;
                overflow_d     = 1'b0;
                stop_pending_d = stop;
                instr_count_d  = '0;
                state_d        = FETCH;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                instruction_d = prog_data;
                state_d       = DECODE;
            end
            DECODE: begin
                if (opcode == '0) state_d = HALT;
                else if (opcode <= OPCODE_WIDTH'(3)) state_d = ISSUE;
                else begin
                    illegal_d = 1'b1;
                    state_d   = NEXT;
                end
            end
            ISSUE: begin
                instr_count_d = &instr_count_q ? instr_count_q : instr_count_q + 16'd1;
                state_d       = WAIT_ACK;
            end
            WAIT_ACK: state_d = finished ? WAIT_ACK : WAIT_DONE;
            WAIT_DONE: if (finished) begin
                state_d = NEXT;
                if (opcode == OPCODE_WIDTH'(2)) begin
                    last_result_d  = result;
                    result_valid_d = 1'b1;
                end
            end
            NEXT: begin
                if (stop_pending_d) state_d = HALT;
                else if (&pc_q) begin
                    overflow_d = 1'b1;
                    state_d    = HALT;
                end else begin
                    pc_d    = pc_q + PROG_ADDR_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            HALT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over run and stop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            instruction_q  <= '0;
            last_result_q  <= '0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            overflow_q     <= 1'b0;
            stop_pending_q <= 1'b0;
            instr_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instruction_q  <= instruction_d;
            last_result_q  <= last_result_d;
            result_valid_q <= result_valid_d;
            illegal_q      <= illegal_d;
            overflow_q     <= overflow_d;
            stop_pending_q <= stop_pending_d;
            instr_count_q  <= instr_count_d;
        end
    end
endmodule

// File: tb/tb_instruction_issuer.sv
// tb_instruction_issuer: scoreboard bench with ROM and datapath models around instruction_issuer.
module tb_instruction_issuer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instruction;
    logic        start;
    logic        finished;
    logic [11:0] result;
    logic [11:0] last_result;
    logic        result_valid, busy, done, illegal, overflow;
    logic [15:0] instr_count;

    instruction_issuer dut (
        .clock(clock), .reset(reset), .run(run), .stop(stop),
        .prog_addr(prog_addr), .prog_data(prog_data), .instruction(instruction),
        .start(start), .finished(finished), .result(result),
        .last_result(last_result), .result_valid(result_valid), .busy(busy),
        .done(done), .illegal(illegal), .overflow(overflow), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t         sb[$];
    logic [31:0] rom [256];
    logic [2:0]  dp_cnt;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          run_cyc = 0;
    int          last_start = 0;
    int          n_start = 0;
    int          fin_rise = 0;
    logic        fin_prev = 1'b0;
    logic        done_seen = 1'b0;

    assign result = 12'hABC;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clock) prog_data <= rom[prog_addr];

    // Datapath model: drops finished after a start, raises it again three cycles later.
    always @(posedge clock) begin
        if (reset) begin
            dp_cnt   <= 3'd0;
            finished <= 1'b1;
        end else if (start) begin
            dp_cnt   <= 3'd3;
            finished <= 1'b0;
        end else if (dp_cnt != 3'd0) begin
            dp_cnt <= dp_cnt - 3'd1;
            if (dp_cnt == 3'd1) finished <= 1'b1;
        end
    end

    function automatic logic [31:0] w(input logic [3:0] op, input logic [27:0] lo);
        return {op, lo};
    endfunction

    function automatic logic [31:0] st(input logic il, input logic ov, input logic [15:0] cnt, input logic [7:0] a);
        return {6'b0, il, ov, cnt, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        sb.push_back('{k, v});
    endtask

    task automatic expect_ev(input int k, input logic [31:0] v, input string name);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected event %0h, required no event", name, v);
        end else begin
            e = sb.pop_front();
            check({name, "_kind"}, 128'(k), 128'(e.kind));
            check(name, 128'(v), 128'(e.val));
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (finished && !fin_prev) fin_rise = cyc;
            fin_prev = finished;
            if (start) begin
                if (n_start == 0) check("start_latency", 128'(cyc), 128'(run_cyc + 4));
                else check("start_spacing", 128'(cyc - last_start >= 4), 128'(1));
                last_start = cyc;
                n_start++;
                expect_ev(0, instruction, "start");
            end
            if (result_valid) begin
                check("rv_timing", 128'(cyc), 128'(fin_rise + 1));
                expect_ev(1, 32'(last_result), "result");
            end
            if (done) begin
                done_seen = 1'b1;
                expect_ev(2, {6'b0, illegal, overflow, instr_count, prog_addr}, "done");
            end
        end
    end

    task automatic launch(input logic with_stop);
        @(negedge clock);
        run       = 1'b1;
        stop      = with_stop;
        run_cyc   = cyc;
        n_start   = 0;
        done_seen = 1'b0;
        @(negedge clock);
        run  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic finish_prog(input string name, input int budget);
        int i = 0;
        while (!done_seen && i < budget) begin
            @(negedge clock);
            i++;
        end
        check({name, "_done"}, 128'(done_seen), 128'(1));
        @(negedge clock);
        check({name, "_busy"}, 128'(busy), 128'(0));
        check({name, "_done_pulse"}, 128'(done), 128'(0));
        check({name, "_drain"}, 128'(sb.size()), 128'(0));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    endtask

    initial begin
        clear_rom();
        repeat (3) @(negedge clock);
        check("reset_outputs", 128'({prog_addr, instruction, start, last_result, result_valid,
              busy, done, illegal, overflow, instr_count}), 128'(0));
        reset = 1'b0;

        rom[0] = w(4'd1, 28'h11);
        rom[1] = w(4'd2, 28'h22);
        rom[2] = w(4'd3, 28'h33);
        rom[3] = w(4'd0, 28'h0);
        push(0, w(4'd1, 28'h11));
        push(0, w(4'd2, 28'h22));
        push(1, 32'hABC);
        push(0, w(4'd3, 28'h33));
        push(2, st(1'b0, 1'b0, 16'd3, 8'd3));
        launch(1'b0);
        finish_prog("prog123", 200);
        check("prog123_starts", 128'(n_start), 128'(3));

        clear_rom();
        rom[0] = w(4'd1, 28'h66);
        rom[1] = w(4'hF, 28'h77);
        push(0, w(4'd1, 28'h66));
        push(2, st(1'b1, 1'b0, 16'd1, 8'd2));
        launch(1'b0);
        finish_prog("illegal", 200);

        clear_rom();
        rom[0] = w(4'd1, 28'h44);
        rom[1] = w(4'd1, 28'h55);
        push(0, w(4'd1, 28'h44));
        push(2, st(1'b0, 1'b0, 16'd1, 8'd0));
        launch(1'b0);
        repeat (4) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        finish_prog("stop_wait_ack", 200);

        push(0, w(4'd1, 28'h44));
        push(2, st(1'b0, 1'b0, 16'd1, 8'd0));
        launch(1'b1);
        finish_prog("run_and_stop", 200);

        for (int i = 0; i < 256; i++) begin
            rom[i] = w(4'd3, 28'(i));
            push(0, w(4'd3, 28'(i)));
        end
        push(2, st(1'b0, 1'b1, 16'd256, 8'd255));
        launch(1'b0);
        finish_prog("overflow", 4000);
        check("overflow_starts", 128'(n_start), 128'(256));

        clear_rom();
        rom[0] = w(4'd1, 28'h88);
        rom[1] = w(4'd2, 28'h99);
        push(0, w(4'd1, 28'h88));
        push(0, w(4'd2, 28'h99));
        launch(1'b0);
        repeat (15) @(negedge clock);
        check("pre_reset_addr", 128'(prog_addr), 128'(1));
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_outputs", 128'({prog_addr, instruction, start, last_result, result_valid,
              busy, done, illegal, overflow, instr_count}), 128'(0));
        check("midrun_reset_drain", 128'(sb.size()), 128'(0));
        reset = 1'b0;
        push(0, w(4'd1, 28'h88));
        push(0, w(4'd2, 28'h99));
        push(1, 32'hABC);
        push(2, st(1'b0, 1'b0, 16'd2, 8'd2));
        launch(1'b0);
        check("restart_addr", 128'(prog_addr), 128'(0));
        finish_prog("restart", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
